// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous input
// in system-clock cycles, with a valid strobe, sticky timeout flag and a
// wrapping count of completed measurements.
module period_meter #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          I_CLK,
  input  logic          rst,
  input  logic          sig_in,
  output logic [W-1:0]  period,
  output logic [W-1:0]  high_time,
  output logic          valid,
  output logic          timeout,
  output logic [CW-1:0] meas_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARM      = 2'd1,
    MEAS     = 2'd2
  } state_t;

  logic          s1_q, s1_d;
  logic          s_q, s_d;
  logic          sig_d_q, sig_d_d;
  // Marks when s holds a real sample of sig_in rather than its reset value,
  // so a signal already high at reset release is not mistaken for a low.
  logic [1:0]    sync_ok_q, sync_ok_d;
  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  hcnt_q, hcnt_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  high_q, high_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] meas_q, meas_d;

  logic          rise;
  logic          cnt_max;

  assign rise    = s_q & ~sig_d_q;
  assign cnt_max = (cnt_q == {W{1'b1}});

  // Next-state logic: synchroniser, edge detector, measurement FSM and outputs.
  always_comb begin
    s1_d      = sig_in;
    s_d       = s1_q;
    sig_d_d   = s_q;
    sync_ok_d = {sync_ok_q[0], 1'b1};
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    meas_d    = meas_q;

    case (state_q)
      WAIT_LOW: begin
        if (sync_ok_q[1] && !s_q) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          cnt_d   = W'(1);
          hcnt_d  = W'(1);
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          // Rise cycle is cycle 1 of the next period, so cnt is the exact
          // edge-to-edge distance. A rise at cnt_max still captures.
          period_d  = cnt_q;
          high_d    = hcnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          meas_d    = meas_q + CW'(1);
          cnt_d     = W'(1);
          hcnt_d    = W'(1);
        end else if (cnt_max) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          hcnt_d    = '0;
          state_d   = ARM;
        end else begin
          cnt_d  = cnt_q + W'(1);
          hcnt_d = hcnt_q + {{(W-1){1'b0}}, s_q};
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s_q       <= 1'b0;
      sig_d_q   <= 1'b0;
      sync_ok_q <= 2'b00;
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      meas_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s_q       <= s_d;
      sig_d_q   <= sig_d_d;
      sync_ok_q <= sync_ok_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      meas_q    <= meas_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign meas_cnt  = meas_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter (W=8, CW=8): directed waveforms plus random
// segments, checked every cycle against an edge-list reference model.
module tb_period_meter;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          I_CLK = 1'b0;
  logic          rst   = 1'b1;
  logic          sig_in = 1'b0;
  logic [W-1:0]  period, high_time;
  logic          valid, timeout;
  logic [CW-1:0] meas_cnt;

  period_meter #(.W(W), .CW(CW)) dut (
    .I_CLK(I_CLK), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time), .valid(valid),
    .timeout(timeout), .meas_cnt(meas_cnt)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct packed {
    logic [W-1:0]  p;
    logic [W-1:0]  h;
    logic          v;
    logic          t;
    logic [CW-1:0] m;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: works on the sequence of input samples taken at each
  // clock edge since reset release. A rising edge is a 0->1 between two real
  // samples; consecutive edges give period and the count of high samples.
  int   m_k, m_start, m_ones;
  bit   m_has;
  logic m_prev;
  exp_t m_out, dly0, dly1;

  task automatic model_reset();
    m_k = 0; m_start = 0; m_ones = 0; m_has = 0; m_prev = 1'b0;
    m_out = '0; dly0 = '0; dly1 = '0;
  endtask

  task automatic model(input logic x, output exp_t r);
    logic rise;
    m_k++;
    rise = (m_k >= 2) && !m_prev && x;
    m_out.v = 1'b0;
    if (m_has) begin
      if (rise) begin
        m_out.p = W'(m_k - m_start);
        m_out.h = W'(m_ones);
        m_out.v = 1'b1;
        m_out.t = 1'b0;
        m_out.m = m_out.m + CW'(1);
        m_start = m_k;
        m_ones  = 0;
      end else if (m_k - m_start == (1 << W) - 1) begin
        m_out.t = 1'b1;
        m_has   = 0;
      end
    end else if (rise) begin
      m_has = 1; m_start = m_k; m_ones = 0;
    end
    if (m_has) m_ones += int'(x);
    m_prev = x;
    r = m_out;
  endtask

  task automatic chk(input string tag, input exp_t e);
    exp_t o;
    o = {period, high_time, valid, timeout, meas_cnt};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s t=%0t obs p=%0d h=%0d v=%0b to=%0b m=%0d exp p=%0d h=%0d v=%0b to=%0b m=%0d",
             tag, $time, o.p, o.h, o.v, o.t, o.m, e.p, e.h, e.v, e.t, e.m);
    end
  endtask

  // One input sample per clock; the DUT shows the effect of a sample two
  // edges after the edge that captured it.
  task automatic step(input logic x);
    exp_t r;
    sig_in = x;
    @(posedge I_CLK);
    model(x, r);
    #1;
    chk("model", dly1);
    dly1 = dly0;
    dly0 = r;
  endtask

  task automatic seg(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge.
  task automatic do_reset(input logic lvl);
    sig_in = lvl;
    rst = 1'b1;
    #2;
    chk("rst_async", '0);
    @(posedge I_CLK);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_ph(input string tag, input logic [W-1:0] p, input logic [W-1:0] h);
    vectors++;
    assert (period === p && high_time === h) else begin
      miscompares++;
      $error("FAIL %s obs p=%0d h=%0d exp p=%0d h=%0d", tag, period, high_time, p, h);
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_init", '0);
    @(posedge I_CLK);
    #1;
    rst = 1'b0;

    // divider N=20
    repeat (2) step(1'b0);
    seg(10, 10, 6);
    chk_ph("div20", 8'd20, 8'd10);

    // 3/5 then 6/2
    seg(3, 5, 4);
    chk_ph("h3l5", 8'd8, 8'd3);
    seg(6, 2, 4);
    chk_ph("h6l2", 8'd8, 8'd6);

    // toggle every cycle
    seg(1, 1, 10);
    chk_ph("tog", 8'd2, 8'd1);

    // one rise then held low long enough to time out, then resume 10/10
    step(1'b1);
    repeat (300) step(1'b0);
    vectors++;
    assert (timeout === 1'b1 && valid === 1'b0 && period === 8'd2) else begin
      miscompares++;
      $error("FAIL tmo_hold obs to=%0b v=%0b p=%0d exp to=1 v=0 p=2", timeout, valid, period);
    end
    seg(10, 10, 3);

    // random segments, occasionally long lows near the timeout limit
    for (int i = 0; i < 40; i++)
      seg($urandom_range(1, 12), $urandom_range(1, 12), 1);
    for (int i = 0; i < 6; i++)
      seg($urandom_range(1, 20), $urandom_range(200, 300), 1);

    // reset in the middle of a measurement
    seg(7, 4, 3);
    repeat (3) step(1'b1);
    do_reset(1'b1);
    seg(10, 10, 3);
    for (int i = 0; i < 10; i++)
      seg($urandom_range(1, 9), $urandom_range(1, 9), 1);

    // high across reset release, then enough fast captures to wrap meas_cnt
    do_reset(1'b1);
    repeat (5) step(1'b1);
    seg(1, 1, 262);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
